// File: rtl/wb_pkg.sv
// Shared constants, entry layout and helpers for the writeback arbiter.
package wb_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int NUM_REGS       = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 2;

    // One buffered long-latency result at the default data width. The top
    // packs {rd, data} in this same order for any DATA_W it is built with.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot decode of a register address into a busy-vector mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with occupancy count and full/empty flags.
// Pushes while full and pops while empty are ignored.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths stay modulo DEPTH.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Entry storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: single-cycle ALU results take the write
// port first; long-latency results wait in a small FIFO and drain when the
// ALU leaves the port free. A busy scoreboard tracks outstanding long ops.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  issue_valid,
    input  logic                  issue_long,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] chk_reg1,
    input  logic [REG_ADDR_W-1:0] chk_reg2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic [CNT_W-1:0]      fifo_count
);

    localparam int ENTRY_W = REG_ADDR_W + DATA_W;

    logic                  alu_sel;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0]     head_data;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_set;
    logic [NUM_REGS-1:0]   busy_clr;

    // Writes to r0 are dropped outright, so an ALU result for r0 neither
    // writes nor takes the port away from the FIFO.
    assign alu_sel   = alu_valid && (alu_rd != '0);
    assign fifo_pop  = !alu_sel && !fifo_empty;

    // Held low during reset; a pop in the same cycle does not open a full FIFO.
    assign mem_ready = reset && !fifo_full;
    assign fifo_push = mem_valid && mem_ready && (mem_rd != '0);

    assign head_rd   = fifo_head[ENTRY_W-1 -: REG_ADDR_W];
    assign head_data = fifo_head[DATA_W-1:0];

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({mem_rd, mem_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Scoreboard set/clear masks; the clear tracks the pop selected this cycle.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (issue_valid && issue_long && (issue_rd != '0))
            busy_set = reg_onehot(issue_rd);
        if (fifo_pop)
            busy_clr = reg_onehot(head_rd);
    end

    // Busy bits: a new issue beats a same-cycle clear; bit 0 never sets.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~busy_clr) | busy_set) & ~NUM_REGS'(1);
        end
    end

    assign chk_busy1 = busy[chk_reg1];
    assign chk_busy2 = busy[chk_reg2];

    // Registered write port: selection in cycle N is visible in cycle N+1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (alu_sel) begin
            reg_write  <= 1'b1;
            write_reg  <= alu_rd;
            write_data <= alu_data;
        end else if (fifo_pop) begin
            reg_write  <= 1'b1;
            write_reg  <= head_rd;
            write_data <= head_data;
        end else begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench for writeback_arbiter: a queue-based
// reference model predicts each register-file write and its cycle, and an
// independent monitor checks the write port against those predictions.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = DEF_FIFO_DEPTH;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_reg1;
    logic [4:0]  chk_reg2;
    logic        chk_busy1;
    logic        chk_busy2;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [1:0]  fifo_count;

    int        checks = 0;
    int        errors = 0;
    int        cyc    = 0;
    exp_t      exp_q[$];
    wb_entry_t mq[$];
    bit [31:0] mbusy;
    bit        last_acc;
    exp_t      mon_e;
    int        acc_n;

    writeback_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .chk_reg1    (chk_reg1),
        .chk_reg2    (chk_reg2),
        .chk_busy1   (chk_busy1),
        .chk_busy2   (chk_busy2),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every write the DUT shows must be the oldest predicted one,
    // in the predicted cycle; a prediction whose cycle passed is a miss.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_write: rd %0d data %0h due cycle %0d, now %0d",
                     exp_q[0].rd, exp_q[0].data, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (reg_write === 1'b1) begin
            checks++;
            if (write_reg == 5'd0) begin
                errors++;
                $display("FAIL r0_write: got write to r0 data %0h expected none (cycle %0d)", write_data, cyc);
            end else if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_write: got rd %0d data %0h expected no write (cycle %0d)",
                         write_reg, write_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (write_reg !== mon_e.rd || write_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_port: got rd %0d data %0h expected rd %0d data %0h (cycle %0d)",
                             write_reg, write_data, mon_e.rd, mon_e.data, cyc);
                end
            end
        end else if (reg_write !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL reg_write_x: got %b expected 0/1 (cycle %0d)", reg_write, cyc);
        end
    end

    task automatic idle();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_data    = '0;
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        issue_rd    = '0;
    endtask

    // One clock with the currently driven inputs: check combinational outputs
    // against the model, advance the model, predict the write, then clock.
    task automatic step();
        wb_entry_t e;
        exp_t      x;
        bit        mr;
        #1;
        mr = (mq.size() < DEPTH);
        chk("mem_ready",  64'(mem_ready),  64'(mr));
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("chk_busy1",  64'(chk_busy1),  64'(mbusy[chk_reg1]));
        chk("chk_busy2",  64'(chk_busy2),  64'(mbusy[chk_reg2]));
        last_acc = mem_valid && mr;
        if (alu_valid && alu_rd != 0) begin
            x = '{rd: alu_rd, data: alu_data, cyc: cyc + 1};
            exp_q.push_back(x);
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            x = '{rd: e.rd, data: e.data, cyc: cyc + 1};
            exp_q.push_back(x);
            mbusy[e.rd] = 1'b0;
        end
        if (last_acc && mem_rd != 0) mq.push_back('{rd: mem_rd, data: mem_data});
        if (issue_valid && issue_long && issue_rd != 0) mbusy[issue_rd] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_reg_write",  64'(reg_write),  64'(0));
        chk("rst_write_reg",  64'(write_reg),  64'(0));
        chk("rst_write_data", 64'(write_data), 64'(0));
        chk("rst_fifo_count", 64'(fifo_count), 64'(0));
        chk("rst_mem_ready",  64'(mem_ready),  64'(0));
        chk("rst_chk_busy1",  64'(chk_busy1),  64'(0));
        chk("rst_chk_busy2",  64'(chk_busy2),  64'(0));
    endtask

    initial begin
        reset    = 1'b0;
        chk_reg1 = 5'd7;
        chk_reg2 = 5'd9;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;
        step();

        // Single ALU write, then one idle cycle.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        idle();
        step();
        step();

        // Long op to r7: busy until the pop cycle, written two cycles after accept.
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        step();
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h11;
        step();
        idle();
        step();
        step();
        step();

        // Three back-to-back long results under a saturated ALU, then drain.
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                alu_valid = 1'b1;
                alu_rd    = 5'($urandom_range(1, 31));
                alu_data  = $urandom();
            end else begin
                alu_valid = 1'b0;
            end
            mem_valid = (acc_n < 3);
            mem_rd    = 5'(acc_n + 1);
            mem_data  = 32'hA0 + 32'(acc_n);
            step();
            if (last_acc) acc_n++;
        end
        idle();
        step();

        // ALU result for r0 must not block the pop of r4.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5A5A;
        step();
        idle();
        step();

        // Pop of r9 with a fresh long issue to r9 in the same cycle.
        chk_reg1 = 5'd9;
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        step();
        idle();
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
        step();
        idle();
        step();
        step();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            alu_valid   = ($urandom_range(0, 1) == 1);
            alu_rd      = 5'($urandom_range(0, 31));
            alu_data    = $urandom();
            mem_valid   = ($urandom_range(0, 1) == 1);
            mem_rd      = 5'($urandom_range(0, 31));
            mem_data    = $urandom();
            issue_valid = ($urandom_range(0, 4) == 0);
            issue_long  = ($urandom_range(0, 1) == 1);
            issue_rd    = 5'($urandom_range(0, 31));
            chk_reg1    = 5'($urandom_range(0, 31));
            chk_reg2    = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        repeat (6) step();

        // Reset with a full FIFO and busy bits pending.
        chk_reg1 = 5'd12;
        chk_reg2 = 5'd13;
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd12;
        step();
        issue_rd = 5'd13;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC12;
        step();
        alu_rd = 5'd2;
        mem_rd = 5'd13; mem_data = 32'hC13;
        step();
        alu_rd = 5'd3;
        mem_valid = 1'b0;
        step();
        chk("fifo_full_before_reset", 64'(fifo_count), 64'(2));
        reset = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        mq.delete();
        mbusy = '0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (6) step();

        chk("pending_writes_at_end", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
